driver_stream_capture: RTL and testbench

//  Receive end of the matrix_mult_wrapper result driver stream (ext_result_o / ext_valid_o).
//  Re-assembles DRIVER_WIDTH-bit beats into WORD_WIDTH-bit result words and writes each

---
 rtl/matrix_mult_pkg.sv | 15 +
 rtl/beat_packer.sv | 55 +++++
 rtl/driver_stream_capture.sv | 147 ++++++++++++++
 tb/tb_driver_stream_capture.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_pkg.sv
// Shared types and default widths for the matrix_mult result return path.
package matrix_mult_pkg;

  localparam int DEF_DRIVER_WIDTH = 8;
  localparam int DEF_WORD_WIDTH   = 32;

  typedef enum logic [2:0] {
    CAP_IDLE    = 3'd0,
    CAP_ARMED   = 3'd1,
    CAP_CAPTURE = 3'd2,
    CAP_FLUSH   = 3'd3,
    CAP_DONE    = 3'd4
  } capture_state_e;

endpackage

// File: rtl/beat_packer.sv
// Assembles DRIVER_WIDTH beats LSB-first into one WORD_WIDTH word.
// word_o already includes the beat being accepted, so the top can register it on the last beat.
module beat_packer #(
  parameter int DRIVER_WIDTH = 8,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_async_i,
  input  logic                    clear_i,
  input  logic                    accept_i,
  input  logic [DRIVER_WIDTH-1:0] beat_i,
  output logic [WORD_WIDTH-1:0]   word_o,
  output logic                    word_done_o,
  output logic                    idx_zero_o
);

  localparam int BEATS = WORD_WIDTH / DRIVER_WIDTH;
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

  logic [IW-1:0]         idx_q;
  logic [WORD_WIDTH-1:0] acc_q;

  always_comb begin
    word_o = acc_q;
    for (int k = 0; k < BEATS; k++) begin
      if (accept_i && (idx_q == IW'(k))) begin
        word_o[k*DRIVER_WIDTH +: DRIVER_WIDTH] = beat_i;
      end
    end
  end

  assign word_done_o = accept_i && (idx_q == LAST_IDX);
  assign idx_zero_o  = (idx_q == '0);

  // The accumulator is cleared after each word so a forced flush comes out zero-padded.
  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (clear_i) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (accept_i) begin
      if (idx_q == LAST_IDX) begin
        idx_q <= '0;
        acc_q <= '0;
      end else begin
        idx_q <= idx_q + IW'(1);
        acc_q <= word_o;
      end
    end
  end

endmodule

// File: rtl/driver_stream_capture.sv
// Captures the result driver stream into a memory port, one write per assembled word.
//
// state   | meaning
// IDLE    | after reset, waiting for start_i
// ARMED   | counters cleared, waiting for the first beat
// CAPTURE | assembling words, watching for stop code / timeout
// FLUSH   | one cycle while the zero-padded partial word is written
// DONE    | capture finished, done_o held until next start_i
module driver_stream_capture
  import matrix_mult_pkg::*;
#(
  parameter int DRIVER_WIDTH = DEF_DRIVER_WIDTH,
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int DEPTH        = 64,
  parameter int TIMEOUT      = 15
) (
  input  logic                     clk_i,
  input  logic                     rstn_async_i,
  input  logic                     en_i,
  input  logic                     start_i,
  input  logic [DRIVER_WIDTH-1:0]  stop_code_i,
  input  logic [DRIVER_WIDTH-1:0]  rx_data_i,
  input  logic                     rx_valid_i,
  output logic                     mem_cenb_o,
  output logic                     mem_wenb_o,
  output logic [$clog2(DEPTH)-1:0] mem_addr_o,
  output logic [WORD_WIDTH-1:0]    mem_d_o,
  output logic [$clog2(DEPTH):0]   word_count_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     overflow_o,
  output logic                     partial_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  capture_state_e        state_q;
  logic [CW-1:0]         ptr_q;
  logic [TW-1:0]         tmr_q;
  logic                  overflow_q;
  logic                  partial_q;

  logic                  in_rx;
  logic                  is_stop;
  logic                  accept;
  logic                  start_go;
  logic                  timeout_hit;
  logic                  write_req;
  logic                  word_done;
  logic                  idx_zero;
  logic [WORD_WIDTH-1:0] word;

  assign in_rx       = (state_q == CAP_ARMED) || (state_q == CAP_CAPTURE);
  assign is_stop     = rx_valid_i && idx_zero && (rx_data_i == stop_code_i);
  assign accept      = en_i && rx_valid_i && in_rx && !is_stop;
  assign start_go    = en_i && start_i && ((state_q == CAP_IDLE) || (state_q == CAP_DONE));
  assign timeout_hit = en_i && (state_q == CAP_CAPTURE) && !rx_valid_i && !idx_zero &&
                       (tmr_q == TW'(1));
  assign write_req   = word_done || timeout_hit;

  beat_packer #(
    .DRIVER_WIDTH (DRIVER_WIDTH),
    .WORD_WIDTH   (WORD_WIDTH)
  ) u_packer (
    .clk_i        (clk_i),
    .rstn_async_i (rstn_async_i),
    .clear_i      (start_go || timeout_hit),
    .accept_i     (accept),
    .beat_i       (rx_data_i),
    .word_o       (word),
    .word_done_o  (word_done),
    .idx_zero_o   (idx_zero)
  );

  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      state_q    <= CAP_IDLE;
      ptr_q      <= '0;
      tmr_q      <= '0;
      overflow_q <= 1'b0;
      partial_q  <= 1'b0;
      mem_cenb_o <= 1'b1;
      mem_wenb_o <= 1'b1;
      mem_addr_o <= '0;
      mem_d_o    <= '0;
    end else begin
      // Strobes drop every cycle, even with en_i low, so a write is always single-cycle.
      mem_cenb_o <= 1'b1;
      mem_wenb_o <= 1'b1;
      if (en_i) begin
        case (state_q)
          CAP_IDLE, CAP_DONE: begin
            if (start_i) begin
              state_q    <= CAP_ARMED;
              ptr_q      <= '0;
              overflow_q <= 1'b0;
              partial_q  <= 1'b0;
            end
          end
          CAP_ARMED: begin
            if (rx_valid_i) begin
              state_q <= is_stop ? CAP_DONE : CAP_CAPTURE;
              tmr_q   <= TW'(TIMEOUT);
            end
          end
          CAP_CAPTURE: begin
            if (rx_valid_i) begin
              if (is_stop) state_q <= CAP_DONE;
              else         tmr_q   <= TW'(TIMEOUT);
            end else if (!idx_zero) begin
              if (tmr_q == TW'(1)) begin
                state_q   <= CAP_FLUSH;
                partial_q <= 1'b1;
              end else begin
                tmr_q <= tmr_q - TW'(1);
              end
            end
          end
          CAP_FLUSH: state_q <= CAP_DONE;
          default:   state_q <= CAP_IDLE;
        endcase

        // No wrap-around: once full, further words only raise overflow.
        if (write_req) begin
          if (ptr_q == CW'(DEPTH)) begin
            overflow_q <= 1'b1;
          end else begin
            mem_cenb_o <= 1'b0;
            mem_wenb_o <= 1'b0;
            mem_addr_o <= ptr_q[AW-1:0];
            mem_d_o    <= word;
            ptr_q      <= ptr_q + CW'(1);
          end
        end
      end
    end
  end

  assign word_count_o = ptr_q;
  assign busy_o       = in_rx;
  assign done_o       = (state_q == CAP_DONE);
  assign overflow_o   = overflow_q;
  assign partial_o    = partial_q;

endmodule

// File: tb/tb_driver_stream_capture.sv
// Self-checking bench for driver_stream_capture against a beat-list reference model.
module tb_driver_stream_capture;

  localparam int DW      = 8;
  localparam int WW      = 32;
  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 15;
  localparam int BEATS   = WW / DW;

  logic          clk_i = 1'b0;
  logic          rstn_async_i;
  logic          en_i;
  logic          start_i;
  logic [DW-1:0] stop_code_i;
  logic [DW-1:0] rx_data_i;
  logic          rx_valid_i;
  logic          mem_cenb_o;
  logic          mem_wenb_o;
  logic [5:0]    mem_addr_o;
  logic [WW-1:0] mem_d_o;
  logic [6:0]    word_count_o;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;
  logic          partial_o;

  driver_stream_capture #(
    .DRIVER_WIDTH (DW),
    .WORD_WIDTH   (WW),
    .DEPTH        (DEPTH),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk_i        (clk_i),
    .rstn_async_i (rstn_async_i),
    .en_i         (en_i),
    .start_i      (start_i),
    .stop_code_i  (stop_code_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .mem_cenb_o   (mem_cenb_o),
    .mem_wenb_o   (mem_wenb_o),
    .mem_addr_o   (mem_addr_o),
    .mem_d_o      (mem_d_o),
    .word_count_o (word_count_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o),
    .partial_o    (partial_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
  } item_t;

  item_t         stim[$];
  logic [WW-1:0] exp_words[$];
  logic          exp_partial;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory-side observer: records every write strobe the DUT issues.
  logic [WW-1:0] dut_mem [DEPTH];
  int            wr_hits [DEPTH];
  int            strobe_cnt;

  always @(negedge clk_i) begin
    if (mem_cenb_o === 1'b0 && mem_wenb_o === 1'b0) begin
      dut_mem[mem_addr_o] = mem_d_o;
      wr_hits[mem_addr_o] = wr_hits[mem_addr_o] + 1;
      strobe_cnt = strobe_cnt + 1;
    end
  end

  localparam logic [50:0] RESET_VEC = {2'b11, 49'd0};

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic clear_monitor();
    for (int i = 0; i < DEPTH; i++) begin
      dut_mem[i] = '0;
      wr_hits[i] = 0;
    end
    strobe_cnt = 0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    tick();
    rx_valid_i = 1'b0;
    rx_data_i  = '0;
  endtask

  task automatic push_item(input logic v, input logic [DW-1:0] d);
    item_t it;
    it.v = v;
    it.d = d;
    stim.push_back(it);
  endtask

  task automatic drive_stim();
    foreach (stim[i]) begin
      rx_valid_i = stim[i].v;
      rx_data_i  = stim[i].d;
      tick();
    end
    rx_valid_i = 1'b0;
    rx_data_i  = '0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_o !== 1'b1; i++) tick();
  endtask

  // Reference: walk the valid beats; a stop code only counts on a word boundary,
  // TIMEOUT idle cycles mid-word flush what is held, zero-padded.
  task automatic run_model();
    logic [DW-1:0] cur[$];
    logic [WW-1:0] w;
    int idle;
    bit fin;
    exp_words.delete();
    exp_partial = 1'b0;
    idle = 0;
    fin = 0;
    foreach (stim[i]) begin
      if (!fin) begin
        if (stim[i].v) begin
          idle = 0;
          if (cur.size() == 0 && stim[i].d == stop_code_i) begin
            fin = 1;
          end else begin
            cur.push_back(stim[i].d);
            if (cur.size() == BEATS) begin
              w = '0;
              foreach (cur[k]) w = w + (WW'(cur[k]) * (WW'(1) << (DW * k)));
              exp_words.push_back(w);
              cur.delete();
            end
          end
        end else if (cur.size() != 0) begin
          idle++;
          if (idle == TIMEOUT) begin
            w = '0;
            foreach (cur[k]) w = w + (WW'(cur[k]) * (WW'(1) << (DW * k)));
            exp_words.push_back(w);
            exp_partial = 1'b1;
            cur.delete();
            fin = 1;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [50:0] obs;
    rstn_async_i = 1'b0;
    en_i = 1'b1; start_i = 1'b0; stop_code_i = 8'hFF;
    rx_data_i = '0; rx_valid_i = 1'b0;
    clear_monitor();
    repeat (3) tick();
    obs = {mem_cenb_o, mem_wenb_o, mem_addr_o, mem_d_o, word_count_o,
           busy_o, done_o, overflow_o, partial_o};
    n_cmp++;
    if (obs !== RESET_VEC) begin
      n_bad++;
      $display("FAIL reset_in: got %h want %h", obs, RESET_VEC);
    end
    rstn_async_i = 1'b1;
    repeat (2) tick();
    obs = {mem_cenb_o, mem_wenb_o, mem_addr_o, mem_d_o, word_count_o,
           busy_o, done_o, overflow_o, partial_o};
    n_cmp++;
    if (obs !== RESET_VEC) begin
      n_bad++;
      $display("FAIL reset_out: got %h want %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_basic();
    stop_code_i = 8'hFF;
    clear_monitor();
    do_start();
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_busy: got %b want 1", busy_o);
    end
    for (int b = 1; b <= 8; b++) begin
      beat(8'(b));
      if (b == 4) begin
        n_cmp++;
        if ({mem_cenb_o, mem_wenb_o, mem_addr_o, mem_d_o} !== {2'b00, 6'd0, 32'h04030201}) begin
          n_bad++;
          $display("FAIL basic_strobe0: got cenb=%b wenb=%b addr=%0d d=%h want 0 0 0 04030201",
                   mem_cenb_o, mem_wenb_o, mem_addr_o, mem_d_o);
        end
      end
    end
    n_cmp++;
    if ({mem_cenb_o, mem_addr_o, mem_d_o, done_o} !== {1'b0, 6'd1, 32'h08070605, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_strobe1: got cenb=%b addr=%0d d=%h done=%b want 0 1 08070605 0",
               mem_cenb_o, mem_addr_o, mem_d_o, done_o);
    end
    beat(8'hFF);
    n_cmp++;
    if ({done_o, busy_o, mem_cenb_o} !== 3'b101) begin
      n_bad++;
      $display("FAIL basic_done: got done=%b busy=%b cenb=%b want 1 0 1", done_o, busy_o, mem_cenb_o);
    end
    tick();
    n_cmp++;
    if ({dut_mem[0], dut_mem[1]} !== {32'h04030201, 32'h08070605}) begin
      n_bad++;
      $display("FAIL basic_mem: got %h %h want 04030201 08070605", dut_mem[0], dut_mem[1]);
    end
    n_cmp++;
    if ({word_count_o, strobe_cnt[7:0], overflow_o, partial_o} !== {7'd2, 8'd2, 2'b00}) begin
      n_bad++;
      $display("FAIL basic_counts: got wc=%0d strobes=%0d ovf=%b part=%b want 2 2 0 0",
               word_count_o, strobe_cnt, overflow_o, partial_o);
    end
  endtask

  task automatic test_stop_first();
    stop_code_i = 8'hFF;
    clear_monitor();
    do_start();
    beat(8'hFF);
    beat(8'h12);
    beat(8'h34);
    repeat (2) tick();
    n_cmp++;
    if ({done_o, word_count_o, strobe_cnt[7:0]} !== {1'b1, 7'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL stop_first: got done=%b wc=%0d strobes=%0d want 1 0 0",
               done_o, word_count_o, strobe_cnt);
    end
    clear_monitor();
    do_start();
    beat(8'h11); beat(8'h00); beat(8'hFF); beat(8'h00);
    beat(8'hFF);
    tick();
    n_cmp++;
    if ({dut_mem[0], word_count_o, done_o} !== {32'h00FF0011, 7'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL stop_midword: got mem0=%h wc=%0d done=%b want 00ff0011 1 1",
               dut_mem[0], word_count_o, done_o);
    end
  endtask

  task automatic test_timeout();
    stop_code_i = 8'hFF;
    clear_monitor();
    do_start();
    beat(8'hAA);
    beat(8'hBB);
    repeat (TIMEOUT - 1) tick();
    n_cmp++;
    if ({busy_o, mem_cenb_o, done_o, partial_o} !== 4'b1100) begin
      n_bad++;
      $display("FAIL timeout_early: got busy=%b cenb=%b done=%b part=%b want 1 1 0 0",
               busy_o, mem_cenb_o, done_o, partial_o);
    end
    tick();
    n_cmp++;
    if ({mem_cenb_o, mem_wenb_o, mem_addr_o, mem_d_o, partial_o, done_o} !==
        {2'b00, 6'd0, 32'h0000BBAA, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_flush: got cenb=%b addr=%0d d=%h part=%b done=%b want 0 0 0000bbaa 1 0",
               mem_cenb_o, mem_addr_o, mem_d_o, partial_o, done_o);
    end
    tick();
    n_cmp++;
    if ({done_o, partial_o, word_count_o, dut_mem[0]} !== {2'b11, 7'd1, 32'h0000BBAA}) begin
      n_bad++;
      $display("FAIL timeout_done: got done=%b part=%b wc=%0d mem0=%h want 1 1 1 0000bbaa",
               done_o, partial_o, word_count_o, dut_mem[0]);
    end
    // Idle on a word boundary must never time out.
    clear_monitor();
    do_start();
    beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
    repeat (3 * TIMEOUT) tick();
    n_cmp++;
    if ({busy_o, done_o, partial_o, word_count_o} !== {3'b100, 7'd1}) begin
      n_bad++;
      $display("FAIL boundary_idle: got busy=%b done=%b part=%b wc=%0d want 1 0 0 1",
               busy_o, done_o, partial_o, word_count_o);
    end
    beat(8'hFF);
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL boundary_stop: got done=%b want 1", done_o);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] d;
    int bad_hits, bad_data;
    stop_code_i = 8'($urandom);
    stim.delete();
    for (int w = 0; w < DEPTH + 1; w++) begin
      for (int k = 0; k < BEATS; k++) begin
        d = 8'($urandom);
        if (k == 0 && d == stop_code_i) d = d ^ 8'h01;
        push_item(1'b1, d);
      end
    end
    push_item(1'b1, stop_code_i);
    push_item(1'b0, 8'h00);
    run_model();
    clear_monitor();
    do_start();
    drive_stim();
    wait_done(20);
    bad_hits = 0;
    bad_data = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_hits[i] != 1) bad_hits++;
      if (dut_mem[i] !== exp_words[i]) bad_data++;
    end
    n_cmp++;
    if ({done_o, overflow_o, partial_o, word_count_o} !== {3'b110, 7'(DEPTH)}) begin
      n_bad++;
      $display("FAIL ovf_flags: got done=%b ovf=%b part=%b wc=%0d want 1 1 0 %0d",
               done_o, overflow_o, partial_o, word_count_o, DEPTH);
    end
    n_cmp++;
    if (strobe_cnt != DEPTH || bad_hits != 0) begin
      n_bad++;
      $display("FAIL ovf_strobes: got strobes=%0d bad_addr_hits=%0d want %0d 0",
               strobe_cnt, bad_hits, DEPTH);
    end
    n_cmp++;
    if (bad_data != 0) begin
      n_bad++;
      $display("FAIL ovf_data: got %0d wrong words want 0", bad_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [50:0] obs;
    stop_code_i = 8'hFF;
    clear_monitor();
    do_start();
    for (int b = 1; b <= 5; b++) beat(8'(b));
    rstn_async_i = 1'b0;
    #2;
    obs = {mem_cenb_o, mem_wenb_o, mem_addr_o, mem_d_o, word_count_o,
           busy_o, done_o, overflow_o, partial_o};
    n_cmp++;
    if (obs !== RESET_VEC) begin
      n_bad++;
      $display("FAIL midreset_async: got %h want %h", obs, RESET_VEC);
    end
    tick();
    rstn_async_i = 1'b1;
    tick();
    obs = {mem_cenb_o, mem_wenb_o, mem_addr_o, mem_d_o, word_count_o,
           busy_o, done_o, overflow_o, partial_o};
    n_cmp++;
    if (obs !== RESET_VEC) begin
      n_bad++;
      $display("FAIL midreset_after: got %h want %h", obs, RESET_VEC);
    end
    clear_monitor();
    do_start();
    beat(8'h21); beat(8'h22); beat(8'h23); beat(8'h24);
    beat(8'hFF);
    wait_done(5);
    tick();
    n_cmp++;
    if ({wr_hits[0][7:0], strobe_cnt[7:0], dut_mem[0], word_count_o, done_o} !==
        {8'd1, 8'd1, 32'h24232221, 7'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL midreset_restart: got hits0=%0d strobes=%0d mem0=%h wc=%0d done=%b want 1 1 24232221 1 1",
               wr_hits[0], strobe_cnt, dut_mem[0], word_count_o, done_o);
    end
  endtask

  task automatic test_enable();
    stop_code_i = 8'hFF;
    clear_monitor();
    do_start();
    beat(8'h10);
    beat(8'h20);
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) beat(8'hEE);
    repeat (2 * TIMEOUT) tick();
    n_cmp++;
    if ({busy_o, done_o, partial_o, strobe_cnt[7:0]} !== {3'b100, 8'd0}) begin
      n_bad++;
      $display("FAIL enable_freeze: got busy=%b done=%b part=%b strobes=%0d want 1 0 0 0",
               busy_o, done_o, partial_o, strobe_cnt);
    end
    en_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL enable_start_ignored: got busy=%b want 1", busy_o);
    end
    beat(8'h30);
    beat(8'h40);
    beat(8'hFF);
    wait_done(5);
    tick();
    n_cmp++;
    if ({dut_mem[0], word_count_o, strobe_cnt[7:0], partial_o, done_o} !==
        {32'h40302010, 7'd1, 8'd1, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL enable_word: got mem0=%h wc=%0d strobes=%0d part=%b done=%b want 40302010 1 1 0 1",
               dut_mem[0], word_count_o, strobe_cnt, partial_o, done_o);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    int nwords, gap, bad_data;
    for (int it = 0; it < 8; it++) begin
      stop_code_i = 8'($urandom);
      stim.delete();
      nwords = $urandom_range(0, 5);
      for (int w = 0; w < nwords; w++) begin
        for (int k = 0; k < BEATS; k++) begin
          gap = (k == 0) ? $urandom_range(0, 20) : $urandom_range(0, TIMEOUT - 1);
          for (int g = 0; g < gap; g++) push_item(1'b0, 8'($urandom));
          d = 8'($urandom);
          if (k == 0 && d == stop_code_i) d = d ^ 8'h01;
          if (k != 0 && $urandom_range(0, 3) == 0) d = stop_code_i;
          push_item(1'b1, d);
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        gap = $urandom_range(0, 5);
        for (int g = 0; g < gap; g++) push_item(1'b0, 8'h00);
        push_item(1'b1, stop_code_i);
      end else begin
        gap = $urandom_range(1, BEATS - 1);
        for (int k = 0; k < gap; k++) begin
          d = 8'($urandom);
          if (k == 0 && d == stop_code_i) d = d ^ 8'h01;
          push_item(1'b1, d);
        end
        for (int g = 0; g < TIMEOUT + 2; g++) push_item(1'b0, 8'h00);
      end
      push_item(1'b0, 8'h00);
      run_model();
      clear_monitor();
      do_start();
      drive_stim();
      wait_done(30);
      tick();
      bad_data = 0;
      for (int i = 0; i < exp_words.size(); i++)
        if (dut_mem[i] !== exp_words[i] || wr_hits[i] != 1) bad_data++;
      n_cmp++;
      if ({done_o, overflow_o, partial_o, word_count_o} !==
          {1'b1, 1'b0, exp_partial, 7'(exp_words.size())}) begin
        n_bad++;
        $display("FAIL random%0d_flags: got done=%b ovf=%b part=%b wc=%0d want 1 0 %b %0d",
                 it, done_o, overflow_o, partial_o, word_count_o, exp_partial, exp_words.size());
      end
      n_cmp++;
      if (strobe_cnt != exp_words.size() || bad_data != 0) begin
        n_bad++;
        $display("FAIL random%0d_data: got strobes=%0d bad_words=%0d want %0d 0",
                 it, strobe_cnt, bad_data, exp_words.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop_first();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
